inst_fetch: RTL and testbench

//  Instruction-fetch stage directly upstream of the IF/ID pipeline register. Owns the fetch PC,

---
 rtl/inst_fetch.sv | 167 ++++++++++++++++
 tb/tb_inst_fetch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch stage feeding the IF/ID register.
// Owns the fetch PC and keeps at most one memory read outstanding. Every
// non-stalled edge presents either a fetched instruction or a bubble. A branch
// redirect squashes whatever fetch is in flight.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_REQ  | request driven at fetch PC, waiting for memory to accept
// S_WAIT | request accepted, waiting for read data
// S_HOLD | read data arrived during a stall, parked in the hold buffer
module inst_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_branch_en,
  input  logic [ADDR_W-1:0] i_branch_target,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_rdy,
  input  logic              i_imem_valid,
  input  logic [INST_W-1:0] i_imem_data,
  output logic [ADDR_W-1:0] o_if_pc,
  output logic [INST_W-1:0] o_if_inst,
  output logic              o_if_valid
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_discard;
  logic [INST_W-1:0] r_hold_buf;
  logic [ADDR_W-1:0] r_if_pc;
  logic [INST_W-1:0] r_if_inst;
  logic              r_if_valid;

  logic              w_accept;
  logic [ADDR_W-1:0] w_br_pc;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] w_fetch_nxt;
  logic [ADDR_W-1:0] w_req_nxt;
  logic              w_discard_nxt;
  logic [INST_W-1:0] w_hold_nxt;
  logic              w_deliver;
  logic [INST_W-1:0] w_deliver_inst;

  // The request is masked during reset so it only rises once reset is released.
  assign o_imem_req  = (r_state == S_REQ) && i_rst_n;
  assign o_imem_addr = r_fetch_pc;
  assign o_if_pc     = r_if_pc;
  assign o_if_inst   = r_if_inst;
  assign o_if_valid  = r_if_valid;

  assign w_accept   = o_imem_req && i_imem_rdy;
  assign w_br_pc    = i_branch_target & ~ADDR_W'(3);
  assign w_pc_plus4 = r_req_pc + ADDR_W'(4);

  // Next-state decode; a branch is applied last so it overrides the normal flow.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_nxt    = r_fetch_pc;
    w_req_nxt      = r_req_pc;
    w_discard_nxt  = r_discard;
    w_hold_nxt     = r_hold_buf;
    w_deliver      = 1'b0;
    w_deliver_inst = r_hold_buf;

    case (r_state)
      S_REQ: begin
        if (w_accept) begin
          w_req_nxt   = r_fetch_pc;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_imem_valid) begin
          if (r_discard) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = S_REQ;
          end else if (!i_stall) begin
            w_deliver      = 1'b1;
            w_deliver_inst = i_imem_data;
            w_fetch_nxt    = w_pc_plus4;
            w_state_nxt    = S_REQ;
          end else begin
            w_hold_nxt  = i_imem_data;
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!i_stall) begin
          w_deliver      = 1'b1;
          w_deliver_inst = r_hold_buf;
          w_fetch_nxt    = w_pc_plus4;
          w_state_nxt    = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase

    if (i_branch_en) begin
      w_fetch_nxt = w_br_pc;
      w_deliver   = 1'b0;
      w_hold_nxt  = '0;
      case (r_state)
        // An accept on the branch cycle fetches the old path; squash its data.
        S_REQ:  w_discard_nxt = w_accept;
        S_WAIT: begin
          if (i_imem_valid) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = S_REQ;
          end else begin
            w_discard_nxt = 1'b1;
          end
        end
        S_HOLD:  w_state_nxt = S_REQ;
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  // Fetch control state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_REQ;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_discard  <= 1'b0;
      r_hold_buf <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_nxt;
      r_req_pc   <= w_req_nxt;
      r_discard  <= w_discard_nxt;
      r_hold_buf <= w_hold_nxt;
    end
  end

  // IF/ID-facing outputs: deliver, bubble, or hold under stall; branch forces a bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_if_pc    <= '0;
      r_if_inst  <= '0;
      r_if_valid <= 1'b0;
    end else if (i_branch_en) begin
      r_if_inst  <= '0;
      r_if_valid <= 1'b0;
    end else if (w_deliver) begin
      r_if_pc    <= r_req_pc;
      r_if_inst  <= w_deliver_inst;
      r_if_valid <= 1'b1;
    end else if (!i_stall) begin
      r_if_inst  <= '0;
      r_if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a per-cycle vector table drives stall, branch,
// memory ready and memory latency, with a behavioural memory that returns
// address-tagged words. Reset-in-flight and PC wrap are checked by hand sequences.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall, br_en, rdy;
  logic [31:0] br_tgt;
  logic [1:0]  lat;

  logic        req, m_valid, if_valid;
  logic [31:0] addr, m_data, if_pc, if_inst;

  logic        w_req, w_m_valid, w_if_valid;
  logic [31:0] w_addr, w_m_data, w_if_pc, w_if_inst;

  int total = 0;
  int bad   = 0;

  inst_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_branch_en(br_en),
    .i_branch_target(br_tgt), .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_rdy(rdy), .i_imem_valid(m_valid), .i_imem_data(m_data),
    .o_if_pc(if_pc), .o_if_inst(if_inst), .o_if_valid(if_valid)
  );

  inst_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(1'b0), .i_branch_en(1'b0),
    .i_branch_target(32'h0), .o_imem_req(w_req), .o_imem_addr(w_addr),
    .i_imem_rdy(1'b1), .i_imem_valid(w_m_valid), .i_imem_data(w_m_data),
    .o_if_pc(w_if_pc), .o_if_inst(w_if_inst), .o_if_valid(w_if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Memory for the main DUT: latency 1 or 2 cycles, selected per vector.
  logic [31:0] pend;
  logic [1:0]  cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_data <= '0; pend <= '0; cnt <= '0;
    end else begin
      m_valid <= 1'b0;
      if (cnt != 0) begin
        cnt <= cnt - 2'd1;
        if (cnt == 2'd1) begin m_valid <= 1'b1; m_data <= tag(pend); end
      end
      if (req && rdy) begin
        pend <= addr;
        if (lat <= 2'd1) begin m_valid <= 1'b1; m_data <= tag(addr); end
        else cnt <= lat - 2'd1;
      end
    end
  end

  // Memory for the wrap instance: fixed 1-cycle latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_m_valid <= 1'b0; w_m_data <= '0;
    end else begin
      w_m_valid <= w_req;
      w_m_data  <= tag(w_addr);
    end
  end

  typedef struct {
    logic        stall, br, rdy;
    logic [1:0]  lat;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t,
                              input logic r, input logic [1:0] l, input logic q,
                              input logic [31:0] a, input logic v, input logic [31:0] p);
    vec_t x;
    x.stall = s; x.br = b; x.tgt = t; x.rdy = r; x.lat = l;
    x.req = q; x.addr = a; x.v = v; x.pc = p;
    x.inst = v ? tag(p) : 32'h0;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  localparam int NV = 41;
  vec_t vt[NV];

  initial begin
    //             stall br tgt       rdy lat req addr     v  pc
    vt[0]  = mk(0, 0, 32'h0,   1, 1, 1, 32'h000, 0, 32'h000);
    vt[1]  = mk(0, 0, 32'h0,   1, 1, 0, 32'h000, 0, 32'h000);
    vt[2]  = mk(0, 0, 32'h0,   1, 1, 1, 32'h004, 1, 32'h000);
    vt[3]  = mk(0, 0, 32'h0,   1, 1, 0, 32'h004, 0, 32'h000);
    vt[4]  = mk(0, 0, 32'h0,   0, 1, 1, 32'h008, 1, 32'h004);
    vt[5]  = mk(0, 0, 32'h0,   0, 1, 1, 32'h008, 0, 32'h004);
    vt[6]  = mk(0, 0, 32'h0,   0, 1, 1, 32'h008, 0, 32'h004);
    vt[7]  = mk(0, 0, 32'h0,   1, 1, 1, 32'h008, 0, 32'h004);
    vt[8]  = mk(0, 0, 32'h0,   1, 1, 0, 32'h008, 0, 32'h004);
    vt[9]  = mk(0, 0, 32'h0,   1, 1, 1, 32'h00C, 1, 32'h008);
    vt[10] = mk(0, 0, 32'h0,   1, 1, 0, 32'h00C, 0, 32'h008);
    vt[11] = mk(1, 0, 32'h0,   1, 1, 1, 32'h010, 1, 32'h00C);
    vt[12] = mk(1, 0, 32'h0,   1, 1, 0, 32'h010, 1, 32'h00C);
    vt[13] = mk(1, 0, 32'h0,   1, 1, 0, 32'h010, 1, 32'h00C);
    vt[14] = mk(1, 0, 32'h0,   1, 1, 0, 32'h010, 1, 32'h00C);
    vt[15] = mk(0, 0, 32'h0,   1, 1, 0, 32'h010, 1, 32'h00C);
    vt[16] = mk(0, 0, 32'h0,   1, 1, 1, 32'h014, 1, 32'h010);
    vt[17] = mk(0, 0, 32'h0,   1, 1, 0, 32'h014, 0, 32'h010);
    vt[18] = mk(0, 0, 32'h0,   1, 1, 1, 32'h018, 1, 32'h014);
    vt[19] = mk(0, 0, 32'h0,   1, 1, 0, 32'h018, 0, 32'h014);
    vt[20] = mk(0, 0, 32'h0,   1, 1, 1, 32'h01C, 1, 32'h018);
    vt[21] = mk(0, 0, 32'h0,   1, 1, 0, 32'h01C, 0, 32'h018);
    vt[22] = mk(0, 0, 32'h0,   1, 2, 1, 32'h020, 1, 32'h01C);
    vt[23] = mk(0, 1, 32'h103, 1, 2, 0, 32'h020, 0, 32'h01C);
    vt[24] = mk(0, 0, 32'h0,   1, 2, 0, 32'h100, 0, 32'h01C);
    vt[25] = mk(0, 0, 32'h0,   1, 2, 1, 32'h100, 0, 32'h01C);
    vt[26] = mk(0, 0, 32'h0,   1, 2, 0, 32'h100, 0, 32'h01C);
    vt[27] = mk(0, 0, 32'h0,   1, 2, 0, 32'h100, 0, 32'h01C);
    vt[28] = mk(0, 1, 32'h200, 1, 1, 1, 32'h104, 1, 32'h100);
    vt[29] = mk(0, 0, 32'h0,   1, 1, 0, 32'h200, 0, 32'h100);
    vt[30] = mk(0, 0, 32'h0,   1, 1, 1, 32'h200, 0, 32'h100);
    vt[31] = mk(0, 0, 32'h0,   1, 1, 0, 32'h200, 0, 32'h100);
    vt[32] = mk(0, 1, 32'h300, 0, 1, 1, 32'h204, 1, 32'h200);
    vt[33] = mk(0, 0, 32'h0,   1, 1, 1, 32'h300, 0, 32'h200);
    vt[34] = mk(0, 0, 32'h0,   1, 1, 0, 32'h300, 0, 32'h200);
    vt[35] = mk(1, 0, 32'h0,   1, 1, 1, 32'h304, 1, 32'h300);
    vt[36] = mk(1, 0, 32'h0,   1, 1, 0, 32'h304, 1, 32'h300);
    vt[37] = mk(1, 1, 32'h404, 1, 1, 0, 32'h304, 1, 32'h300);
    vt[38] = mk(0, 0, 32'h0,   1, 1, 1, 32'h404, 0, 32'h300);
    vt[39] = mk(0, 0, 32'h0,   1, 1, 0, 32'h404, 0, 32'h300);
    vt[40] = mk(0, 0, 32'h0,   1, 1, 1, 32'h408, 1, 32'h404);

    rst_n = 1'b0; stall = 1'b0; br_en = 1'b0; br_tgt = '0; rdy = 1'b1; lat = 2'd1;

    // Reset state while reset is held.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",     32'(req),      32'h0);
    chk("rst_addr",    addr,          32'h0);
    chk("rst_valid",   32'(if_valid), 32'h0);
    chk("rst_pc",      if_pc,         32'h0);
    chk("rst_inst",    if_inst,       32'h0);
    chk("rst_wrap_ad", w_addr,        32'hFFFF_FFFC);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      stall = vt[i].stall; br_en = vt[i].br; br_tgt = vt[i].tgt;
      rdy = vt[i].rdy; lat = vt[i].lat;
      #1;
      chk($sformatf("v%0d_req", i),   32'(req),      32'(vt[i].req));
      chk($sformatf("v%0d_addr", i),  addr,          vt[i].addr);
      chk($sformatf("v%0d_valid", i), 32'(if_valid), 32'(vt[i].v));
      chk($sformatf("v%0d_pc", i),    if_pc,         vt[i].pc);
      chk($sformatf("v%0d_inst", i),  if_inst,       vt[i].inst);
      @(negedge clk);
    end

    // Reset while the fetch for 0x408 is outstanding.
    stall = 1'b0; br_en = 1'b0; br_tgt = '0; rdy = 1'b1; lat = 2'd1;
    #1;
    chk("midrst_pre_req", 32'(req), 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_req",   32'(req),      32'h0);
    chk("midrst_addr",  addr,          32'h0);
    chk("midrst_valid", 32'(if_valid), 32'h0);
    chk("midrst_pc",    if_pc,         32'h0);
    chk("midrst_inst",  if_inst,       32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req",      32'(req),   32'h1);
    chk("rel_addr",     addr,       32'h0);
    chk("rel_wrap_req", 32'(w_req), 32'h1);
    chk("rel_wrap_ad",  w_addr,     32'hFFFF_FFFC);

    // Wrap of fetch PC past the top of the address space.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("wrap_valid", 32'(w_if_valid), 32'h1);
    chk("wrap_pc",    w_if_pc,         32'hFFFF_FFFC);
    chk("wrap_inst",  w_if_inst,       tag(32'hFFFF_FFFC));
    chk("wrap_addr",  w_addr,          32'h0);
    chk("wrap_req",   32'(w_req),      32'h1);
    chk("post_valid", 32'(if_valid),   32'h1);
    chk("post_pc",    if_pc,           32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("wrap2_pc",   w_if_pc,   32'h0);
    chk("wrap2_inst", w_if_inst, tag(32'h0));
    chk("wrap2_addr", w_addr,    32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
